serial_adder: RTL and testbench

- Bit-serial N-bit adder that consumes the team's Half_Adder_Gate cell.
- Two Half_Adder_Gate instances plus an OR form a full-adder cell; a carry flip-flop closes the loop.
- Operand shift registers feed the cell LSB-first, one bit per clock.
- Sits between a register-file/operand source and any consumer needing a low-area sum, using start/done handshake.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/Half_Adder_Gate.sv | 12 +
 rtl/serial_fa_cell.sv | 28 ++
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/Half_Adder_Gate.sv
// Team half-adder cell: sum = a ^ b, carry = a & b.
module Half_Adder_Gate (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full adder made from two Half_Adder_Gate cells and an OR.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  Half_Adder_Gate u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s0),
    .carry(c0)
  );

  Half_Adder_Gate u_ha1 (
    .a    (s0),
    .b    (ci),
    .sum  (s),
    .carry(c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a `sub` input for a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             load, shift, finish;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-2:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and inject the +1 through the carry.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  serial_fa_cell u_fa (
    .a (a_q[0]),
    .b (b_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_co)
  );

  // Incoming sum bit enters at the MSB; after WIDTH shifts it lands at bit 0.
  assign acc_next = {fa_s, acc_q};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
      if (load) begin
        a_q     <= a;
        b_q     <= b_load;
        carry_q <= carry_init;
        cnt_q   <= '0;
      end else if (shift) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        acc_q   <= acc_next[WIDTH-1:1];
        carry_q <= fa_co;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (finish) begin
        sum_q  <= acc_next;
        cout_q <= fa_co;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs. an arithmetic model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always @(negedge clk) if (busy && done) excl_viol++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {cout, sum} from plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt, output bit to);
    lat = 0; busy_cnt = 0; to = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W:0] exp);
    int lat, bc;
    bit to;
    launch(x, y, s);
    wait_done(lat, bc, to);
    check({tag, "_timeout"}, to, 0);
    check({tag, "_lat"}, lat, W);
    check({tag, "_busy"}, bc, W);
    check({tag, "_res"}, {cout, sum}, exp);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int nd;
    int t[2];
    logic [W:0] r[2];
    logic [W-1:0] x, y;
    logic s;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", {busy, done, cout, sum}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_out", {busy, done, cout, sum}, 0);

    run_op("t1", 8'h35, 8'h4A, 1'b0, 9'h07F);

    run_op("t2", 8'hFF, 8'h01, 1'b0, 9'h100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold", {cout, sum}, 9'h100);
    end

    // Re-pulse of start during SHIFT must be ignored.
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; r[0] = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        nd++;
        r[0] = {cout, sum};
      end
      @(negedge clk);
    end
    check("t3_ndone", nd, 1);
    check("t3_res", r[0], 9'h046);

    // Async reset mid-operation.
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t4_async", {busy, done, cout, sum}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("t4_nodone", nd, 0);
    run_op("t4b", 8'h01, 8'h01, 1'b0, 9'h002);

    // Back-to-back with start held across DONE.
    @(negedge clk);
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    a = 8'h7F; b = 8'h01;
    nd = 0; t[0] = 0; t[1] = 0; r[0] = '0; r[1] = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (nd < 2) begin
          t[nd] = i;
          r[nd] = {cout, sum};
        end
        nd++;
      end else if (nd >= 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("t5_ndone", nd, 2);
    check("t5_first", t[0], W);
    check("t5_gap", t[1] - t[0], W + 1);
    check("t5_res0", r[0], 9'h100);
    check("t5_res1", r[1], 9'h080);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("t6a", 8'h10, 8'h01, 1'b1, 9'h10F);
    run_op("t6b", 8'h01, 8'h02, 1'b1, 9'h0FF);
`endif

    for (int i = 0; i < 30; i++) begin
      x = W'($urandom);
      y = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op("rnd", x, y, s, model(x, y, s));
    end

    check("excl", excl_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
